// File: rtl/cbs_pkg.sv
// rtl/cbs_pkg.sv - shared constants, width helpers and saturation for the Conv-BN-SiLU lanes
// Purpose: tap indexing, hard-SiLU constants, datapath width derivation, sat().
// Ports: none (package).
package cbs_pkg;

  localparam int TAPS      = 9;
  localparam int HSILU_MUL = 43;
  localparam int HSILU_SH  = 8;
  localparam int SAT_W     = 64;

  function automatic int tap_idx(input int r, input int k);
    return r * 3 + k;
  endfunction

  function automatic int prod_w(input int dw, input int cw);
    return dw + cw;
  endfunction

  // 4 guard bits cover the growth of a 9-term sum.
  function automatic int acc_w(input int dw, input int cw);
    return dw + cw + 4;
  endfunction

  // Room for acc*scale, the 32-bit bias and the rounding constant.
  function automatic int v_w(input int aw, input int bw);
    return ((aw + bw > 32) ? aw + bw : 32) + 2;
  endfunction

  function automatic logic signed [SAT_W-1:0] sat(input logic signed [SAT_W-1:0] x, input int w);
    logic signed [SAT_W-1:0] hi;
    logic signed [SAT_W-1:0] lo;
    hi = (64'sd1 <<< (w - 1)) - 64'sd1;
    lo = -(64'sd1 <<< (w - 1));
    if (x > hi) return hi;
    if (x < lo) return lo;
    return x;
  endfunction

endpackage

// File: rtl/cbs_if.sv
// rtl/cbs_if.sv - input/output beat bundle for the Conv-BN-SiLU array
// Purpose: groups both valid/ready handshakes and their payloads.
// Ports: master drives in_valid/data_in/filter/bn_scale/bn_bias/act_en/out_ready;
//        slave (the array) drives in_ready/out_valid/data_out/out_sat.
interface cbs_if
  import cbs_pkg::*;
#(
  parameter int NUM_CH  = 3,
  parameter int OUT_PIX = 8,
  parameter int DATA_W  = 8,
  parameter int COEF_W  = 8,
  parameter int BN_W    = 16
) ();

  logic                                     in_valid;
  logic                                     in_ready;
  logic [NUM_CH*3*(OUT_PIX+2)*DATA_W-1:0]   data_in;
  logic [NUM_CH*TAPS*COEF_W-1:0]            filter;
  logic [NUM_CH*BN_W-1:0]                   bn_scale;
  logic [NUM_CH*32-1:0]                     bn_bias;
  logic                                     act_en;
  logic                                     out_valid;
  logic                                     out_ready;
  logic [NUM_CH*OUT_PIX*DATA_W-1:0]         data_out;
  logic [NUM_CH-1:0]                        out_sat;

  modport master (
    output in_valid, data_in, filter, bn_scale, bn_bias, act_en, out_ready,
    input  in_ready, out_valid, data_out, out_sat
  );

  modport slave (
    input  in_valid, data_in, filter, bn_scale, bn_bias, act_en, out_ready,
    output in_ready, out_valid, data_out, out_sat
  );

endinterface

// File: rtl/cbs_lane.sv
// rtl/cbs_lane.sv - one channel's four-stage conv / batch-norm / hard-SiLU datapath
// Purpose: S1 products, S2 accumulate, S3 scale+bias+round+shift, S4 activation and saturation.
// Ports: clk, rst (async active-low), i_en (stage advance), i_pix (3-row strip), i_taps (3x3),
//        i_scale, i_bias, i_act_en, o_data (OUT_PIX pixels), o_sat (any pixel clipped).
module cbs_lane
  import cbs_pkg::*;
#(
  parameter int OUT_PIX  = 8,
  parameter int DATA_W   = 8,
  parameter int COEF_W   = 8,
  parameter int BN_W     = 16,
  parameter int SHIFT    = 8,
  parameter int ACT_FRAC = 4
) (
  input  logic                              clk,
  input  logic                              rst,
  input  logic                              i_en,
  input  logic [3*(OUT_PIX+2)*DATA_W-1:0]   i_pix,
  input  logic [TAPS*COEF_W-1:0]            i_taps,
  input  logic [BN_W-1:0]                   i_scale,
  input  logic [31:0]                       i_bias,
  input  logic                              i_act_en,
  output logic [OUT_PIX*DATA_W-1:0]         o_data,
  output logic                              o_sat
);

  localparam int PW    = prod_w(DATA_W, COEF_W);
  localparam int AW    = acc_w(DATA_W, COEF_W);
  localparam int VW    = v_w(AW, BN_W);
  localparam int YW    = VW + ACT_FRAC + 12;
  localparam int ONE   = 1 << ACT_FRAC;
  localparam int STRIP = OUT_PIX + 2;
  localparam logic signed [VW-1:0] RND = VW'(1) << (SHIFT - 1);

  logic signed [PW-1:0]       w_prod [OUT_PIX][TAPS];
  logic signed [AW-1:0]       w_acc  [OUT_PIX];
  logic signed [VW-1:0]       w_v    [OUT_PIX];
  logic [OUT_PIX*DATA_W-1:0]  w_data;
  logic [OUT_PIX-1:0]         w_clip;

  logic signed [PW-1:0]       r_prod [OUT_PIX][TAPS];
  logic signed [AW-1:0]       r_acc  [OUT_PIX];
  logic signed [VW-1:0]       r_v    [OUT_PIX];
  logic signed [BN_W-1:0]     r_scale1, r_scale2;
  logic signed [31:0]         r_bias1, r_bias2;
  logic                       r_act1, r_act2, r_act3;
  logic [OUT_PIX*DATA_W-1:0]  r_data;
  logic                       r_sat;

  always_comb begin
    w_prod = '{default: '0};
    for (int j = 0; j < OUT_PIX; j++)
      for (int r = 0; r < 3; r++)
        for (int k = 0; k < 3; k++)
          w_prod[j][tap_idx(r, k)] =
            PW'($signed(i_pix[(r*STRIP+j+k)*DATA_W +: DATA_W])) *
            PW'($signed(i_taps[tap_idx(r, k)*COEF_W +: COEF_W]));
  end

  always_comb begin
    for (int j = 0; j < OUT_PIX; j++) begin
      w_acc[j] = '0;
      for (int t = 0; t < TAPS; t++)
        w_acc[j] = w_acc[j] + AW'(r_prod[j][t]);
    end
  end

  always_comb begin
    for (int j = 0; j < OUT_PIX; j++)
      w_v[j] = (VW'(r_acc[j]) * VW'(r_scale2) + VW'(r_bias2) + RND) >>> SHIFT;
  end

  always_comb begin : s4_comb
    logic signed [VW-1:0]    t;
    logic signed [YW-1:0]    cl;
    logic signed [YW-1:0]    hs;
    logic signed [SAT_W-1:0] pre;
    logic signed [SAT_W-1:0] s;
    t      = '0;
    cl     = '0;
    hs     = '0;
    pre    = '0;
    s      = '0;
    w_data = '0;
    w_clip = '0;
    for (int j = 0; j < OUT_PIX; j++) begin
      // Hard-SiLU: v * clamp(v+3, 0, 6) / 6, with /6 approximated by *43 >> 8.
      t = r_v[j] + VW'(3 * ONE);
      if (t < 0)                  cl = '0;
      else if (t > VW'(6 * ONE))  cl = YW'(6 * ONE);
      else                        cl = YW'(t);
      hs  = (YW'(r_v[j]) * cl * YW'(HSILU_MUL)) >>> (HSILU_SH + ACT_FRAC);
      pre = r_act3 ? SAT_W'(hs) : SAT_W'(r_v[j]);
      s   = sat(pre, DATA_W);
      w_data[j*DATA_W +: DATA_W] = s[DATA_W-1:0];
      w_clip[j] = (s != pre);
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_prod   <= '{default: '0};
      r_acc    <= '{default: '0};
      r_v      <= '{default: '0};
      r_scale1 <= '0;
      r_scale2 <= '0;
      r_bias1  <= '0;
      r_bias2  <= '0;
      r_act1   <= 1'b0;
      r_act2   <= 1'b0;
      r_act3   <= 1'b0;
      r_data   <= '0;
      r_sat    <= 1'b0;
    end else if (i_en) begin
      r_prod   <= w_prod;
      r_scale1 <= i_scale;
      r_bias1  <= i_bias;
      r_act1   <= i_act_en;
      r_acc    <= w_acc;
      r_scale2 <= r_scale1;
      r_bias2  <= r_bias1;
      r_act2   <= r_act1;
      r_v      <= w_v;
      r_act3   <= r_act2;
      r_data   <= w_data;
      r_sat    <= |w_clip;
    end
  end

  assign o_data = r_data;
  assign o_sat  = r_sat;

endmodule

// File: rtl/cbs_array.sv
// rtl/cbs_array.sv - NUM_CH-lane pipelined Conv-BN-SiLU row block
// Purpose: shared valid chain and handshake over NUM_CH cbs_lane datapaths.
// Ports: clk, rst (async active-low), bus (cbs_if slave: input beat in, output beat out).
module cbs_array
  import cbs_pkg::*;
#(
  parameter int NUM_CH   = 3,
  parameter int OUT_PIX  = 8,
  parameter int DATA_W   = 8,
  parameter int COEF_W   = 8,
  parameter int BN_W     = 16,
  parameter int SHIFT    = 8,
  parameter int ACT_FRAC = 4
) (
  input  logic  clk,
  input  logic  rst,
  cbs_if.slave  bus
);

  localparam int STRIP = OUT_PIX + 2;

  logic [4:1] r_vld;
  logic       w_adv;

  // The whole pipe moves together; it only stalls when S4 holds an unconsumed beat.
  assign w_adv         = !(r_vld[4] && !bus.out_ready);
  assign bus.in_ready  = w_adv;
  assign bus.out_valid = r_vld[4];

  always_ff @(posedge clk or negedge rst) begin
    if (!rst)       r_vld <= '0;
    else if (w_adv) r_vld <= {r_vld[3:1], bus.in_valid};
  end

  for (genvar c = 0; c < NUM_CH; c++) begin : g_lane
    cbs_lane #(
      .OUT_PIX (OUT_PIX),
      .DATA_W  (DATA_W),
      .COEF_W  (COEF_W),
      .BN_W    (BN_W),
      .SHIFT   (SHIFT),
      .ACT_FRAC(ACT_FRAC)
    ) u_lane (
      .clk     (clk),
      .rst     (rst),
      .i_en    (w_adv),
      .i_pix   (bus.data_in[c*3*STRIP*DATA_W +: 3*STRIP*DATA_W]),
      .i_taps  (bus.filter[c*TAPS*COEF_W +: TAPS*COEF_W]),
      .i_scale (bus.bn_scale[c*BN_W +: BN_W]),
      .i_bias  (bus.bn_bias[c*32 +: 32]),
      .i_act_en(bus.act_en),
      .o_data  (bus.data_out[c*OUT_PIX*DATA_W +: OUT_PIX*DATA_W]),
      .o_sat   (bus.out_sat[c])
    );
  end

endmodule

// File: doc/cbs_array.md
Name: cbs_array

Overview:
Parametrised, pipelined successor of the fixed three-lane Conv-BN-SiLU row block. It has NUM_CH independent lanes. Each lane takes a 3-row pixel strip and a 3x3 kernel and computes OUT_PIX conv outputs, then applies a batch-norm scale/bias with rounding and saturation, then an optional hard-SiLU. It sits between the line-buffer feeder and the concat/downsample stage of the YOLOv7 backbone, with valid/ready handshakes on both sides.

Parameters:
NUM_CH, 3, number of parallel lanes
OUT_PIX, 8, output pixels per lane per beat; the input strip is OUT_PIX+2 columns wide
DATA_W, 8, signed pixel and output width
COEF_W, 8, signed kernel tap width
BN_W, 16, signed BN scale width
SHIFT, 8, requantisation right-shift, >=1
ACT_FRAC, 4, fractional bits of the pre-activation value

Ports:
clk  in  1  clock, rising edge
rst  in  1  asynchronous, active-low reset
in_valid  in  1  input beat valid
in_ready  out  1  block can accept a beat
data_in  in  NUM_CH*3*(OUT_PIX+2)*DATA_W  pixel (c,r,j) at bit offset ((c*3+r)*(OUT_PIX+2)+j)*DATA_W
filter  in  NUM_CH*9*COEF_W  tap (c,r,k) at bit offset (c*9+r*3+k)*COEF_W
bn_scale  in  NUM_CH*BN_W  per-lane signed scale
bn_bias  in  NUM_CH*32  per-lane signed bias, added before the shift
act_en  in  1  1 = hard-SiLU, 0 = linear
out_valid  out  1  output beat valid
out_ready  in  1  downstream accepts
data_out  out  NUM_CH*OUT_PIX*DATA_W  pixel (c,j) at bit offset (c*OUT_PIX+j)*DATA_W
out_sat  out  NUM_CH  lane c clipped at least one pixel in this beat

Behaviour:
- Clock and reset: one clock, clk. Reset rst is asynchronous and active-low. While rst=0: all stage valids=0, out_valid=0, data_out=0, out_sat=0. Beats in flight when reset asserts are discarded, with no partial output. in_ready may be 1 during reset, but nothing is accepted while rst=0.
- Handshake: a beat transfers on a rising edge when in_valid=1 and in_ready=1. All inputs (data_in, filter, bn_scale, bn_bias, act_en) are sampled together in that beat.
- Pipeline: four registered stages S1-S4, throughput 1 beat/cycle.
  - Global advance: adv = !(s4_valid && !out_ready). in_ready = adv.
  - When adv=0, every stage holds. data_out, out_sat and out_valid stay stable until out_ready=1.
  - out_valid = s4_valid.
  - A beat accepted at edge t is visible at the output after edge t+3.
  - Bubbles propagate as stage valid=0. Beat order is preserved.
- Stage arithmetic, per lane c and pixel j:
  - S1: products p[r][k] = d[r][j+k]*w[r*3+k], signed, each DATA_W+COEF_W wide. act_en travels with the beat.
  - S2: acc = sum of the 9 products, DATA_W+COEF_W+4 bits, exact with no overflow.
  - S3: v = (acc*scale + bias + (1<<(SHIFT-1))) >>> SHIFT, computed at full width.
  - S4 when act_en=0: y = sat(v).
  - S4 when act_en=1: ONE = 1<<ACT_FRAC; cl = clamp(v + 3*ONE, 0, 6*ONE); y = sat((v*cl*43) >>> (8+ACT_FRAC)).
  - sat() clips to [-2^(DATA_W-1), 2^(DATA_W-1)-1]. out_sat[c] is the OR of per-pixel clip events in lane c.
- Every intermediate is computed at full precision. The only lossy steps are the >>> operations and sat(). The bench reference model must use exactly this arithmetic.
- Simultaneous events: when S4 drains (out_ready=1) on the same edge a new beat enters, both happen on that edge. There is no bubble and no duplicate.
- All lanes share one handshake. Lanes cannot stall independently.

Decomposition:
- Shared package cbs_pkg holds:
  - TAPS=9 and the tap index function r*3+k
  - the HSILU_MUL=43 and HSILU_SH=8 constants
  - width-derivation functions: product width, accumulator width
  - the sat() helper function
- Sub-module cbs_lane: one channel's S1-S4 datapath, taking an external stage-enable. cbs_array owns the valid chain, the handshake and the generate loop over NUM_CH.

Test Plan:
- Default parameters, all pixels=1, all taps=1, scale=256, bias=0, act_en=0 -> every output pixel = 9, out_sat=0, out_valid high after edge t+3.
- Same beat with act_en=1 -> every pixel = 5, since (9*57*43)>>12 = 5.
- Pixels=127, taps=127, scale=256 -> outputs=127, out_sat=all ones. Pixels=-128 with act_en=1 -> outputs=0 (cl=0), out_sat=0.
- Continuous 20 distinct beats with out_ready held low for cycles 6-10 -> in_ready low in exactly those cycles, data_out stable while stalled, all 20 results delivered in order with no loss or duplicate.
- Pull rst low mid-stream with 3 beats in flight -> out_valid=0 and data_out=0 immediately (asynchronously). After release, the first new beat emerges alone, with none of the discarded beats.
- NUM_CH=5, OUT_PIX=16 build; bias=-1024, scale=256, pixels/taps=0 -> outputs=-4, confirming the lane and pixel indexing of data_out.
